// File: rtl/pqr5_core_pkg.sv
// Shared PQR5 core definitions: datapath width, load funct3 encodings, WB state type.
`ifndef PQR5_XLEN
`define PQR5_XLEN 32
`endif

package pqr5_core_pkg;

    localparam int unsigned XLEN = `PQR5_XLEN;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LD
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a raw load word and sign/zero-extends it.
module load_align
    import pqr5_core_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lsb,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr_lsb, 3'b000} +: 8];
        lane_h = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
            F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// PQR5 writeback stage: registered single-cycle RF write, forwarding bus and retire counter.
module writeback
    import pqr5_core_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_rd_we,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_is_load,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lsb,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_rf_wren,
    output logic [4:0]      o_rf_rdt_addr,
    output logic [XLEN-1:0] o_rf_rdt_data,
    output logic            o_fwd_valid,
    output logic [4:0]      o_fwd_addr,
    output logic [XLEN-1:0] o_fwd_data,
    output logic            o_retire,
    output logic [63:0]     o_instret
);

    wb_state_t       state_q, state_d;
    logic            pend_we;
    logic [4:0]      pend_rd;
    logic [2:0]      pend_f3;
    logic [1:0]      pend_lsb;

    logic [2:0]      al_f3;
    logic [1:0]      al_lsb;
    logic [XLEN-1:0] al_data;

    logic            fire, capture, wr_we;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    logic            rf_wren_q, retire_q;
    logic [4:0]      rf_addr_q;
    logic [XLEN-1:0] rf_data_q;
    logic [63:0]     instret_q;

    // Aligner sees live inputs in IDLE and the latched load attributes in WAIT_LD.
    always_comb begin
        al_f3  = (state_q == WAIT_LD) ? pend_f3  : i_funct3;
        al_lsb = (state_q == WAIT_LD) ? pend_lsb : i_addr_lsb;
    end

    load_align u_align (
        .funct3   (al_f3),
        .addr_lsb (al_lsb),
        .rdata    (i_dmem_rdata),
        .data     (al_data)
    );

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        capture = 1'b0;
        wr_we   = i_rd_we;
        wr_rd   = i_rd_addr;
        wr_data = i_alu_result;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (!i_is_load) begin
                        fire = 1'b1;
                    end else if (i_dmem_rvalid) begin
                        fire    = 1'b1;
                        wr_data = al_data;
                    end else begin
                        capture = 1'b1;
                        state_d = WAIT_LD;
                    end
                end
            end
            WAIT_LD: begin
                wr_we   = pend_we;
                wr_rd   = pend_rd;
                wr_data = al_data;
                if (i_dmem_rvalid) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            pend_we   <= 1'b0;
            pend_rd   <= '0;
            pend_f3   <= '0;
            pend_lsb  <= '0;
            rf_wren_q <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            retire_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            if (capture) begin
                pend_we  <= i_rd_we;
                pend_rd  <= i_rd_addr;
                pend_f3  <= i_funct3;
                pend_lsb <= i_addr_lsb;
            end
            rf_wren_q <= fire && wr_we && (wr_rd != 5'd0);
            if (fire) begin
                rf_addr_q <= wr_rd;
                rf_data_q <= wr_data;
            end
            retire_q  <= fire;
            instret_q <= instret_q + {63'd0, retire_q};
        end
    end

    assign o_ready       = (state_q == IDLE);
    assign o_rf_wren     = rf_wren_q;
    assign o_rf_rdt_addr = rf_addr_q;
    assign o_rf_rdt_data = rf_data_q;
    assign o_fwd_valid   = FWD_EN ? rf_wren_q : 1'b0;
    assign o_fwd_addr    = rf_addr_q;
    assign o_fwd_data    = rf_data_q;
    assign o_retire      = retire_q;
    assign o_instret     = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Randomized + directed bench for writeback against a transaction-level reference model.
module tb_writeback;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_rd_we = 1'b0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_is_load = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [1:0]  i_addr_lsb = '0;
    logic [31:0] i_alu_result = '0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_rf_wren;
    logic [4:0]  o_rf_rdt_addr;
    logic [31:0] o_rf_rdt_data;
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_addr;
    logic [31:0] o_fwd_data;
    logic        o_retire;
    logic [63:0] o_instret;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    writeback #(.FWD_EN(1'b1)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_rd_we       (i_rd_we),
        .i_rd_addr     (i_rd_addr),
        .i_is_load     (i_is_load),
        .i_funct3      (i_funct3),
        .i_addr_lsb    (i_addr_lsb),
        .i_alu_result  (i_alu_result),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_rf_wren     (o_rf_wren),
        .o_rf_rdt_addr (o_rf_rdt_addr),
        .o_rf_rdt_data (o_rf_rdt_data),
        .o_fwd_valid   (o_fwd_valid),
        .o_fwd_addr    (o_fwd_addr),
        .o_fwd_data    (o_fwd_data),
        .o_retire      (o_retire),
        .o_instret     (o_instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a retiring instruction must write, from the ISA load rules.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lsb,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(lsb))) & 32'hFF;
        h = (w >> (16 * int'(lsb[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    bit          m_pend;
    logic        m_pwe;
    logic [4:0]  m_prd;
    logic [2:0]  m_pf3;
    logic [1:0]  m_plsb;
    bit          m_wren, m_retire;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [63:0] m_instret;

    always @(posedge clk or negedge aresetn) begin
        bit          ret;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
        if (!aresetn) begin
            m_pend = 0; m_wren = 0; m_retire = 0; m_instret = '0;
        end else begin
            m_instret = m_instret + 64'(m_retire);
            ret = 0; we = i_rd_we; rd = i_rd_addr; val = i_alu_result;
            if (m_pend) begin
                if (i_dmem_rvalid) begin
                    ret = 1; we = m_pwe; rd = m_prd;
                    val = m_load(m_pf3, m_plsb, i_dmem_rdata);
                    m_pend = 0;
                end
            end else if (i_valid) begin
                if (!i_is_load) ret = 1;
                else if (i_dmem_rvalid) begin
                    ret = 1;
                    val = m_load(i_funct3, i_addr_lsb, i_dmem_rdata);
                end else begin
                    m_pend = 1; m_pwe = i_rd_we; m_prd = i_rd_addr;
                    m_pf3 = i_funct3; m_plsb = i_addr_lsb;
                end
            end
            m_retire = ret;
            m_wren = ret && we && (rd != 5'd0);
            if (m_wren) begin
                m_addr = rd; m_data = val;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", 64'(o_ready), 64'(!m_pend));
            chk("wren", 64'(o_rf_wren), 64'(m_wren));
            chk("fwd_valid", 64'(o_fwd_valid), 64'(m_wren));
            chk("retire", 64'(o_retire), 64'(m_retire));
            chk("instret", o_instret, m_instret);
            if (m_wren) begin
                chk("rf_addr", 64'(o_rf_rdt_addr), 64'(m_addr));
                chk("rf_data", 64'(o_rf_rdt_data), 64'(m_data));
                chk("fwd_addr", 64'(o_fwd_addr), 64'(m_addr));
                chk("fwd_data", 64'(o_fwd_data), 64'(m_data));
            end
        end
    end

    task automatic idle_in();
        i_valid = 1'b0;
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic we, input logic [4:0] rd, input logic [31:0] alu,
                         input logic rv, input logic [31:0] rdat);
        i_valid = 1'b1; i_is_load = ld; i_funct3 = f3; i_addr_lsb = lsb;
        i_rd_we = we; i_rd_addr = rd; i_alu_result = alu;
        i_dmem_rvalid = rv; i_dmem_rdata = rdat;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 aresetn = 1'b0;
        idle_in();
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wren"}, 64'(o_rf_wren), 64'd0);
        chk({tag, "_addr"}, 64'(o_rf_rdt_addr), 64'd0);
        chk({tag, "_data"}, 64'(o_rf_rdt_data), 64'd0);
        chk({tag, "_fwdv"}, 64'(o_fwd_valid), 64'd0);
        chk({tag, "_fwda"}, 64'(o_fwd_addr), 64'd0);
        chk({tag, "_fwdd"}, 64'(o_fwd_data), 64'd0);
        chk({tag, "_retire"}, 64'(o_retire), 64'd0);
        chk({tag, "_instret"}, o_instret, 64'd0);
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
    endtask

    task automatic lb_case(input logic [2:0] f3, input logic [31:0] want, input string tag);
        @(negedge clk);
        issue(1'b1, f3, 2'd3, 1'b1, 5'd9, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({tag, "_ready_low"}, 64'(o_ready), 64'd0);
            idle_in();
            if (k == 2) begin
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata = 32'h80FF_1234;
            end
        end
        @(negedge clk);
        chk({tag, "_wren"}, 64'(o_rf_wren), 64'd1);
        chk({tag, "_data"}, 64'(o_rf_rdt_data), 64'(want));
        chk({tag, "_model"}, 64'(m_data), 64'(want));
        idle_in();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        aresetn = 1'b1;
        cmp_en = 1'b1;

        // ALU op rd=5
        @(negedge clk);
        issue(1'b0, 3'd0, 2'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
        @(negedge clk);
        idle_in();
        chk("alu_wren", 64'(o_rf_wren), 64'd1);
        chk("alu_addr", 64'(o_rf_rdt_addr), 64'd5);
        chk("alu_data", 64'(o_rf_rdt_data), 64'hDEAD_BEEF);
        chk("alu_fwd", 64'(o_fwd_valid), 64'd1);
        chk("alu_retire", 64'(o_retire), 64'd1);
        @(negedge clk);
        chk("alu_instret", o_instret, 64'd1);

        lb_case(3'b000, 32'hFFFF_FF80, "lb");
        lb_case(3'b100, 32'h0000_0080, "lbu");

        // LH with same-cycle rvalid
        @(negedge clk);
        issue(1'b1, 3'b001, 2'd2, 1'b1, 5'd12, 32'h0, 1'b1, 32'h8001_7FFF);
        @(negedge clk);
        idle_in();
        chk("lh_ready", 64'(o_ready), 64'd1);
        chk("lh_data", 64'(o_rf_rdt_data), 64'hFFFF_8001);
        chk("lh_model", 64'(m_data), 64'hFFFF_8001);

        // rd=0 then rd_we=0
        do_reset();
        @(negedge clk);
        issue(1'b0, 3'd0, 2'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 32'h0);
        @(negedge clk);
        issue(1'b0, 3'd0, 2'd0, 1'b0, 5'd7, 32'h1111_2222, 1'b0, 32'h0);
        chk("rd0_wren", 64'(o_rf_wren), 64'd0);
        chk("rd0_fwd", 64'(o_fwd_valid), 64'd0);
        chk("rd0_retire", 64'(o_retire), 64'd1);
        @(negedge clk);
        idle_in();
        chk("nowe_wren", 64'(o_rf_wren), 64'd0);
        chk("nowe_fwd", 64'(o_fwd_valid), 64'd0);
        chk("nowe_retire", 64'(o_retire), 64'd1);
        @(negedge clk);
        chk("rd0_instret", o_instret, 64'd2);

        // reset while a load is pending
        @(negedge clk);
        issue(1'b1, 3'b010, 2'd0, 1'b1, 5'd3, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        idle_in();
        chk("wait_ready", 64'(o_ready), 64'd0);
        #2 aresetn = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        idle_in();
        chk("midrst_wren", 64'(o_rf_wren), 64'd0);
        chk("midrst_retire", 64'(o_retire), 64'd0);
        chk("midrst_ready", 64'(o_ready), 64'd1);

        // counter wrap
        @(negedge clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(1'b0, 3'd0, 2'd0, 1'b1, 5'd1, 32'h5, 1'b0, 32'h0);
        @(negedge clk);
        idle_in();
        release dut.instret_q;
        chk("wrap_retire", 64'(o_retire), 64'd1);
        @(negedge clk);
        chk("wrap_instret", o_instret, 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n == 1500) begin
                #2 aresetn = 1'b0;
                @(negedge clk);
                aresetn = 1'b1;
            end
            i_valid       = ($urandom_range(0, 3) != 0);
            i_is_load     = 1'($urandom_range(0, 1));
            i_funct3      = 3'($urandom);
            i_addr_lsb    = 2'($urandom);
            i_rd_we       = ($urandom_range(0, 4) != 0);
            i_rd_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            i_alu_result  = $urandom;
            i_dmem_rvalid = ($urandom_range(0, 2) == 0);
            i_dmem_rdata  = $urandom;
        end
        @(negedge clk);
        idle_in();
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
